acc_core_ctrl: RTL and testbench

//  Fetch/decode/execute controller directly upstream of the alu block.

---
 rtl/acc_core_ctrl_pkg.sv | 60 ++++++
 rtl/acc_core_ctrl_regfile.sv | 29 ++
 rtl/acc_core_ctrl.sv | 139 +++++++++++++
 tb/tb_acc_core_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_ctrl_pkg.sv
// acc_core_ctrl shared types: FSM states, alu unit codes,
// instruction layout and the execute-stage decode helper.
package acc_core_ctrl_pkg;

  localparam int NREGS    = 4;
  localparam int IDX_W    = 2;
  localparam int OP_BIT   = 4;
  localparam int MODE_BIT = 3;

  typedef enum logic [1:0] {
    FETCH,
    FETCH_IMM,
    EXEC,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    U_ADD = 3'b000,
    U_AND = 3'b001,
    U_SHF = 3'b010,
    U_LD  = 3'b011,
    U_OR  = 3'b100,
    U_XOR = 3'b101,
    U_MUL = 3'b110,
    U_SPC = 3'b111
  } unit_t;

  typedef struct packed {
    unit_t            unit;
    logic             op;
    logic             mode;
    logic             rsv;
    logic [IDX_W-1:0] idx;
  } instr_t;

  typedef struct packed {
    logic wb;
    logic bnez;
    logic store;
    logic halt;
  } ctl_t;

  function automatic ctl_t decode(
    input instr_t i
  );
    ctl_t c;
    logic spc;
    c   = '0;
    spc = (i.unit == U_SPC);
    unique case (1'b1)
      !spc:                   c.wb    = 1'b1;
      spc && !i.op:           c.bnez  = 1'b1;
      spc && i.op && !i.mode: c.store = 1'b1;
      spc && i.op && i.mode:  c.halt  = 1'b1;
      default:                c       = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_core_ctrl_regfile.sv
// regfile_4x8: four 8-bit registers, one sync write port,
// one comb read port, synchronous active-low clear.
module regfile_4x8
  import acc_core_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/acc_core_ctrl.sv
// acc_core_ctrl: fetch/decode/execute controller feeding the alu.
// Owns pc, acc, instr/imm and the 4x8 register file.
//  clk_in/rst_n_in     : clock, sync active-low reset
//  imem_req/addr/ack/data : req/ack byte fetch port
//  unit_sel/op_sel/acc/src : alu controls and operands
//  alu_res_in          : comb alu result, written back in EXEC
//  retire_out/halted_out : execute pulse, halt status
module acc_core_ctrl
  import acc_core_ctrl_pkg::*;
#(
  parameter int PC_W = 8
)
(
  input  logic            clk_in,
  input  logic            rst_n_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [7:0]      imem_data_in,
  output logic [2:0]      unit_sel_out,
  output logic            op_sel_out,
  output logic [7:0]      acc_out,
  output logic [7:0]      src_out,
  input  logic [7:0]      alu_res_in,
  output logic            retire_out,
  output logic            halted_out
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      acc;
  logic [7:0]      imm;
  instr_t          instr;
  ctl_t            ctl;
  logic [7:0]      rf_rd;
  logic [7:0]      src;
  logic            rf_we;
  logic            fetch_hs;
  logic            in_exec;
  logic            unused_rsv;

  assign ctl        = decode(instr);
  assign in_exec    = (state == EXEC);
  assign rf_we      = in_exec && ctl.store;
  assign src        = instr.mode ? imm : rf_rd;
  assign unused_rsv = instr.rsv;

  // req is registered, so a handshake is only
  // accepted while the request is visible.
  assign fetch_hs = imem_req_out && imem_ack_in;

  assign imem_addr_out = pc;
  assign acc_out       = acc;
  assign src_out       = src;

  regfile_4x8 u_rf (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .we      (rf_we),
    .wr_idx  (instr.idx),
    .wr_data (acc),
    .rd_idx  (instr.idx),
    .rd_data (rf_rd)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state        <= FETCH;
      pc           <= '0;
      acc          <= '0;
      imm          <= '0;
      instr        <= '0;
      imem_req_out <= 1'b0;
      unit_sel_out <= U_SPC;
      op_sel_out   <= 1'b0;
      retire_out   <= 1'b0;
      halted_out   <= 1'b0;
    end else begin
      retire_out <= 1'b0;
      unique case (state)
        FETCH: begin
          imem_req_out <= 1'b1;
          if (fetch_hs) begin
            instr <= instr_t'(imem_data_in);
            pc    <= pc + PC_W'(1);
            if (imem_data_in[MODE_BIT]) begin
              state <= FETCH_IMM;
            end else begin
              state        <= EXEC;
              imem_req_out <= 1'b0;
              unit_sel_out <= imem_data_in[7:5];
              op_sel_out   <= imem_data_in[OP_BIT];
              retire_out   <= 1'b1;
            end
          end
        end
        FETCH_IMM: begin
          if (fetch_hs) begin
            imm          <= imem_data_in;
            pc           <= pc + PC_W'(1);
            state        <= EXEC;
            imem_req_out <= 1'b0;
            unit_sel_out <= instr.unit;
            op_sel_out   <= instr.op;
            retire_out   <= 1'b1;
          end
        end
        EXEC: begin
          unit_sel_out <= U_SPC;
          op_sel_out   <= 1'b0;
          if (ctl.wb) begin
            acc <= alu_res_in;
          end
          // absolute branch target; pc already points past it
          if (ctl.bnez && (acc != '0)) begin
            pc <= PC_W'(src);
          end
          if (ctl.halt) begin
            state      <= HALT;
            halted_out <= 1'b1;
          end else begin
            state        <= FETCH;
            imem_req_out <= 1'b1;
          end
        end
        HALT: begin
          imem_req_out <= 1'b0;
          halted_out   <= 1'b1;
          unit_sel_out <= U_SPC;
          op_sel_out   <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_ctrl.sv
// Bench for acc_core_ctrl: behavioural alu and imem with random
// ack delay, checked against an instruction-level reference model.
module tb_acc_core_ctrl;

  logic       clk;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] unit_sel;
  logic       op_sel;
  logic [7:0] acc;
  logic [7:0] src;
  logic [7:0] alu_res;
  logic       retire;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;
  int sub1_cnt = 0;

  acc_core_ctrl #(.PC_W(8)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .imem_req_out  (imem_req),
    .imem_addr_out (imem_addr),
    .imem_ack_in   (imem_ack),
    .imem_data_in  (imem_data),
    .unit_sel_out  (unit_sel),
    .op_sel_out    (op_sel),
    .acc_out       (acc),
    .src_out       (src),
    .alu_res_in    (alu_res),
    .retire_out    (retire),
    .halted_out    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] alu_f(
    input logic [2:0] u,
    input logic       op,
    input logic [7:0] a,
    input logic [7:0] s
  );
    logic [15:0] p;
    p = a * s;
    case (u)
      3'd0:    return op ? a - s : a + s;
      3'd1:    return op ? ~(a & s) : (a & s);
      3'd2:    return op ? a >> s[2:0] : a << s[2:0];
      3'd3:    return s;
      3'd4:    return a | s;
      3'd5:    return a ^ s;
      3'd6:    return p[7:0];
      default: return a;
    endcase
  endfunction

  always_comb alu_res = alu_f(unit_sel, op_sel, acc, src);

  logic [7:0]  mem [256];
  int unsigned max_dly = 0;
  int unsigned dly = 0;
  int unsigned cnt = 0;
  logic        spur = 1'b0;

  assign imem_ack  = imem_req ? (cnt >= dly) : spur;
  assign imem_data = imem_ack ? mem[imem_addr] : ~mem[imem_addr];

  always @(posedge clk) begin
    spur <= 1'($urandom_range(1, 0));
    if (!rst_n) begin
      cnt <= 0;
    end else if (imem_req && imem_ack) begin
      cnt <= 0;
      dly <= $urandom_range(max_dly, 0);
    end else if (imem_req) begin
      cnt <= cnt + 1;
    end
  end

  task automatic check8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs,
                        input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  logic       prev_pend = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  always @(negedge clk) begin
    if (rst_n && prev_pend) begin
      check1("req_hold", imem_req, 1'b1);
      check8("addr_hold", imem_addr, prev_addr);
    end
    prev_pend <= rst_n && imem_req && !imem_ack;
    prev_addr <= imem_addr;
  end

  logic [7:0] m_pc;
  logic [7:0] m_acc;
  logic [7:0] m_r [4];
  logic       m_halt;

  task automatic model_reset();
    m_pc   = 8'h00;
    m_acc  = 8'h00;
    m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic model_step(output logic [2:0] eu, output logic eo,
                            output logic [7:0] es);
    logic [7:0] b;
    logic [7:0] im;
    b    = mem[m_pc];
    m_pc = m_pc + 8'd1;
    im   = 8'h00;
    if (b[3]) begin
      im   = mem[m_pc];
      m_pc = m_pc + 8'd1;
    end
    es = b[3] ? im : m_r[b[1:0]];
    eu = b[7:5];
    eo = b[4];
    if (eu != 3'd7) m_acc = alu_f(eu, eo, m_acc, es);
    else if (!eo) begin
      if (m_acc != 8'h00) m_pc = es;
    end
    else if (!b[3]) m_r[b[1:0]] = m_acc;
    else m_halt = 1'b1;
  endtask

  task automatic exec_check(input string tag);
    int n;
    logic [2:0] eu;
    logic eo;
    logic [7:0] es;
    n = 0;
    while (retire !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_retire"}, retire, 1'b1);
    model_step(eu, eo, es);
    check8({tag, "_unit"}, {5'd0, unit_sel}, {5'd0, eu});
    check1({tag, "_op"}, op_sel, eo);
    check8({tag, "_src"}, src, es);
    if (unit_sel == 3'd0 && op_sel && src == 8'h01) sub1_cnt++;
    @(negedge clk);
    check1({tag, "_pulse"}, retire, 1'b0);
    check8({tag, "_acc"}, acc, m_acc);
    check1({tag, "_halted"}, halted, m_halt);
    if (!m_halt) check8({tag, "_pc"}, imem_addr, m_pc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic halt_hold(input string tag);
    repeat (20) begin
      @(negedge clk);
      check1({tag, "_req0"}, imem_req, 1'b0);
      check1({tag, "_hlt"}, halted, 1'b1);
      check8({tag, "_usel"}, {5'd0, unit_sel}, 8'h07);
    end
  endtask

  task automatic post_reset_state(input string tag);
    check1({tag, "_req"}, imem_req, 1'b0);
    check8({tag, "_acc"}, acc, 8'h00);
    check8({tag, "_pc"}, imem_addr, 8'h00);
    check8({tag, "_usel"}, {5'd0, unit_sel}, 8'h07);
    check1({tag, "_op"}, op_sel, 1'b0);
    check1({tag, "_ret"}, retire, 1'b0);
    check1({tag, "_hlt"}, halted, 1'b0);
  endtask

  initial begin
    logic [7:0] prog [19];
    int n;
    logic [2:0] u;
    rst_n = 1'b0;
    prog = '{8'h68, 8'h05, 8'h08, 8'h03, 8'h18, 8'h0A, 8'h58,
             8'h04, 8'hF1, 8'h68, 8'h00, 8'h61, 8'h68, 8'h03,
             8'h18, 8'h01, 8'hE8, 8'h0E, 8'hF8};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 19; i++) mem[i] = prog[i];
    max_dly = 4;
    model_reset();
    repeat (3) @(negedge clk);
    post_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check1("req_after_rst", imem_req, 1'b1);

    for (int k = 1; k <= 15; k++) begin
      exec_check("prog");
      if (k == 2)  check8("ld_add", acc, 8'h08);
      if (k == 3)  check8("sub_wrap", acc, 8'hFE);
      if (k == 4)  check8("shr4", acc, 8'h0F);
      if (k == 7)  check8("ld_r1", acc, 8'h0F);
      if (k == 14) check8("loop_exit", acc, 8'h00);
    end
    check8("sub_retires", 8'(sub1_cnt), 8'd3);
    check1("prog_halted", halted, 1'b1);
    halt_hold("halt1");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      u = 3'($urandom_range(6, 0));
      mem[8'h00] = 8'h68;
      mem[8'h01] = 8'h01;
      mem[8'h02] = 8'hE8;
      mem[8'h03] = 8'hFC;
      mem[8'hFC] = 8'h68;
      mem[8'hFD] = 8'($urandom_range(255, 0));
      mem[8'hFE] = {u, 1'($urandom_range(1, 0)), 1'b1, 3'b000};
      mem[8'hFF] = 8'($urandom_range(255, 0));
      do_reset();
      for (int k = 1; k <= 12; k++) begin
        exec_check("wrap");
        if (k == 4) check8("pc_wrap", imem_addr, 8'h00);
      end
    end

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(255, 0));
      if (mem[i][7:3] == 5'b11111) mem[i] = mem[i] & 8'hF7;
    end
    do_reset();
    for (int k = 0; k < 60; k++) exec_check("rand");

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h68;
    mem[1] = 8'h55;
    mem[2] = 8'h61;
    mem[3] = 8'hF8;
    mem[4] = 8'h00;
    do_reset();
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 8'h01) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check1("reach_fimm", imem_req && imem_addr == 8'h01, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    post_reset_state("rst_fimm");
    rst_n = 1'b1;
    model_reset();
    n = 0;
    while (retire !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check1("reach_exec", retire, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    post_reset_state("rst_exec");
    rst_n = 1'b1;
    model_reset();
    exec_check("post");
    check8("ld55", acc, 8'h55);
    exec_check("post");
    check8("r1_cleared", acc, 8'h00);
    exec_check("post");
    check1("final_halt", halted, 1'b1);
    halt_hold("halt2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
